// File: rtl/piece_preview_queue.sv
`default_nettype none
// ============================================================================
// Module      : piece_preview_queue
// Description : Preview queue for the next-piece generator with spawn and hold/swap handling.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_preview_queue #(
    parameter int DEPTH      = 3,
    parameter int NUM_PIECES = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           gen_piece,
    input  logic                 spawn_req,
    input  logic                 hold_req,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_piece,
    output logic [3*DEPTH-1:0]   preview,
    output logic [2:0]           queue_count,
    output logic [2:0]           active_piece,
    output logic                 active_valid,
    output logic [2:0]           hold_piece,
    output logic                 hold_valid,
    output logic                 hold_used
);

    localparam logic [2:0] c_DEPTH      = 3'(DEPTH);
    localparam logic [3:0] c_NUM_PIECES = 4'(NUM_PIECES);

    logic [2:0] r_q [DEPTH];
    logic [2:0] r_count;
    logic       r_skip;
    logic [2:0] r_last;
    logic       r_last_valid;
    logic       r_pending;
    logic       r_pend_hold;
    logic [2:0] r_active;
    logic       r_active_valid;
    logic [2:0] r_hold;
    logic       r_hold_valid;
    logic       r_hold_used;
    logic       r_spawn_valid;

    logic       w_hold_ok;
    logic       w_hold_swap;
    logic       w_hold_pop;
    logic       w_pop_req;
    logic       w_pop;
    logic       w_pend_next;
    logic [2:0] w_cnt_after;
    logic       w_gen_legal;
    logic       w_room;
    logic       w_repeat;
    logic       w_enq;
    logic       w_skip;

    // Hold is refused right after a spawn pulse so pulses never sit back to back.
    assign w_hold_ok   = hold_req && !spawn_req && r_active_valid && !r_hold_used &&
                         !r_pending && !r_spawn_valid;
    assign w_hold_swap = w_hold_ok && r_hold_valid;
    assign w_hold_pop  = w_hold_ok && !r_hold_valid;

    // A pop request that cannot be served now (empty queue or pulse last cycle) stays pending.
    assign w_pop_req   = spawn_req || r_pending || w_hold_pop;
    assign w_pop       = w_pop_req && (r_count != 3'd0) && !r_spawn_valid;
    assign w_pend_next = w_pop_req && !w_pop;

    assign w_cnt_after = r_count - {2'b00, w_pop};
    assign w_gen_legal = ({1'b0, gen_piece} < c_NUM_PIECES);
    assign w_room      = (w_cnt_after < c_DEPTH);
    assign w_repeat    = r_last_valid && (gen_piece == r_last) && !r_skip;
    assign w_enq       = w_room && w_gen_legal && !w_repeat;
    assign w_skip      = w_room && w_gen_legal && w_repeat;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [2:0] w_shift;
        logic [2:0] w_next;

        if (i == DEPTH - 1) begin : g_tail
            assign w_shift = 3'd0;
        end else begin : g_body
            assign w_shift = r_q[i+1];
        end

        always_comb begin
            w_next = w_pop ? w_shift : r_q[i];
            if (w_enq && (w_cnt_after == 3'(i))) begin
                w_next = gen_piece;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q[i] <= 3'd0;
            end else begin
                r_q[i] <= w_next;
            end
        end

        assign preview[3*i +: 3] = r_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= 3'd0;
            r_skip         <= 1'b0;
            r_last         <= 3'd0;
            r_last_valid   <= 1'b0;
            r_pending      <= 1'b0;
            r_pend_hold    <= 1'b0;
            r_active       <= 3'd0;
            r_active_valid <= 1'b0;
            r_hold         <= 3'd0;
            r_hold_valid   <= 1'b0;
            r_hold_used    <= 1'b0;
            r_spawn_valid  <= 1'b0;
        end else begin
            r_count       <= w_cnt_after + {2'b00, w_enq};
            r_spawn_valid <= w_pop || w_hold_swap;
            r_pending     <= w_pend_next;
            r_pend_hold   <= w_pend_next && (r_pend_hold || w_hold_pop);

            if (w_enq) begin
                r_last       <= gen_piece;
                r_last_valid <= 1'b1;
                r_skip       <= 1'b0;
            end else if (w_skip) begin
                r_skip <= 1'b1;
            end

            // A deferred hold keeps hold_used set once its replacement piece arrives.
            if (w_pop) begin
                r_active       <= r_q[0];
                r_active_valid <= 1'b1;
                r_hold_used    <= w_hold_pop || r_pend_hold;
            end

            if (w_hold_pop) begin
                r_hold       <= r_active;
                r_hold_valid <= 1'b1;
                r_hold_used  <= 1'b1;
            end

            if (w_hold_swap) begin
                r_active    <= r_hold;
                r_hold      <= r_active;
                r_hold_used <= 1'b1;
            end
        end
    end

    assign spawn_valid  = r_spawn_valid;
    assign spawn_piece  = r_active;
    assign active_piece = r_active;
    assign active_valid = r_active_valid;
    assign queue_count  = r_count;
    assign hold_piece   = r_hold;
    assign hold_valid   = r_hold_valid;
    assign hold_used    = r_hold_used;

endmodule
`default_nettype wire
